// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundle of the CPU-side request/response handshake and the word-RAM bus of
// mem_access_unit.
//   master  : CPU side (drives req_*, receives req_ready and resp_*)
//   slave   : memory access unit view of the CPU channel
//   ram_mst : unit view of the word RAM (drives ram_*, receives ram_data)
//   ram_slv : word RAM view
// -----------------------------------------------------------------------------
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

interface mem_access_unit_if #(
    parameter int ADDR_W = `RAM_ADDRESS_BITWIDTH
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_write_data;
    logic [31:0]       ram_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

    modport ram_mst (
        output ram_wren, ram_address, ram_write_data,
        input  ram_data
    );

    modport ram_slv (
        input  ram_wren, ram_address, ram_write_data,
        output ram_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Converts byte/halfword/word CPU loads and stores into accesses to a 32-bit
// word RAM with a one-cycle read latency. Sub-word stores are done as
// read-modify-write; loads are lane-extracted and sign/zero-extended.
// Misaligned or illegal-size requests complete with resp_err and never touch
// the RAM.
//
// Ports
//   clk, rstn         clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; ready only while idle
//   req_we            1 = store, 0 = load
//   req_size          0 byte, 1 halfword, 2 word, 3 illegal
//   req_unsigned      zero-extend sub-word loads
//   req_addr/wdata    byte address, right-aligned store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata/err    load data / error flag, held until the next completion
//   ram_wren          word-RAM write enable (one cycle per store)
//   ram_address       word-aligned byte address, 0 when not accessing
//   ram_write_data    word-RAM write data
//   ram_data          word-RAM read data, valid the cycle after the address
// -----------------------------------------------------------------------------
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

module mem_access_unit #(
    parameter int ADDR_W = `RAM_ADDRESS_BITWIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_write_data,
    input  logic [31:0]       ram_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Misalignment / illegal-size detection.
    function automatic logic req_error(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            2'd0:    err = 1'b0;
            2'd1:    err = lane[0];
            2'd2:    err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Pick the addressed little-endian lane out of a RAM word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            2'd2:    r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the old RAM word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = old;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            2'd1: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              ram_wren_q, ram_wren_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [31:0]       ram_write_data_q, ram_write_data_d;

    // Next-state logic and request capture.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_error(req_size, req_addr[1:0])) begin
                        state_d = RESP;
                    end else if (req_we && (req_size == 2'd2)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered output values derived from the state being entered.
    always_comb begin
        req_ready_d      = (state_d == IDLE);
        resp_valid_d     = (state_d == RESP);
        ram_wren_d       = (state_d == WR);
        ram_address_d    = {ADDR_W{1'b0}};
        ram_write_data_d = 32'h0000_0000;
        resp_rdata_d     = resp_rdata_q;
        resp_err_d       = resp_err_q;

        if ((state_d == RD_ADDR) || (state_d == RD_DATA) || (state_d == WR)) begin
            ram_address_d = {addr_d[ADDR_W-1:2], 2'b00};
        end else begin
            ram_address_d = {ADDR_W{1'b0}};
        end

        // Entering WR from RD_DATA means a sub-word store: merge into the
        // word just read. Entering from IDLE means a full-word store.
        if (state_d == WR) begin
            if (state_q == RD_DATA) begin
                ram_write_data_d = merge_store(ram_data, wdata_q, size_q, addr_q[1:0]);
            end else begin
                ram_write_data_d = wdata_d;
            end
        end else begin
            ram_write_data_d = 32'h0000_0000;
        end

        // Response fields are only updated on entry into RESP and then held.
        if (state_d == RESP) begin
            case (state_q)
                IDLE: begin
                    resp_rdata_d = 32'h0000_0000;
                    resp_err_d   = 1'b1;
                end
                RD_DATA: begin
                    resp_rdata_d = load_extract(ram_data, size_q, addr_q[1:0], uns_q);
                    resp_err_d   = 1'b0;
                end
                default: begin
                    resp_rdata_d = 32'h0000_0000;
                    resp_err_d   = 1'b0;
                end
            endcase
        end else begin
            resp_rdata_d = resp_rdata_q;
            resp_err_d   = resp_err_q;
        end
    end

    // State, captured request and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            we_q             <= 1'b0;
            size_q           <= 2'd0;
            uns_q            <= 1'b0;
            addr_q           <= {ADDR_W{1'b0}};
            wdata_q          <= 32'h0000_0000;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'h0000_0000;
            resp_err_q       <= 1'b0;
            ram_wren_q       <= 1'b0;
            ram_address_q    <= {ADDR_W{1'b0}};
            ram_write_data_q <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            we_q             <= we_d;
            size_q           <= size_d;
            uns_q            <= uns_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            ram_wren_q       <= ram_wren_d;
            ram_address_q    <= ram_address_d;
            ram_write_data_q <= ram_write_data_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign ram_wren       = ram_wren_q;
    assign ram_address    = ram_address_q;
    assign ram_write_data = ram_write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench: directed scenarios plus randomized loads/stores checked
// against a byte-addressed reference memory. A word RAM with one-cycle read
// latency is modelled next to the DUT.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    localparam int AW = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    mem_access_unit_if #(.ADDR_W(AW)) bus ();

    mem_access_unit #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (bus.req_valid),
        .req_ready      (bus.req_ready),
        .req_we         (bus.req_we),
        .req_size       (bus.req_size),
        .req_unsigned   (bus.req_unsigned),
        .req_addr       (bus.req_addr),
        .req_wdata      (bus.req_wdata),
        .resp_valid     (bus.resp_valid),
        .resp_rdata     (bus.resp_rdata),
        .resp_err       (bus.resp_err),
        .ram_wren       (bus.ram_wren),
        .ram_address    (bus.ram_address),
        .ram_write_data (bus.ram_write_data),
        .ram_data       (bus.ram_data)
    );

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // word RAM, 64 words, one-cycle read latency
    logic [31:0] tb_ram [0:63];
    always @(posedge clk) begin
        if (bus.ram_wren) tb_ram[bus.ram_address[7:2]] <= bus.ram_write_data;
        bus.ram_data <= tb_ram[bus.ram_address[7:2]];
    end

    // reference memory as plain bytes
    logic [7:0] ref_mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] last_rdata;
    logic [31:0] last_wd;
    int          last_lat;
    int          last_accept;
    int          last_resp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // Issue one request and check its whole life against the reference model.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [7:0] addr, input logic [31:0] wdata, input bit hold);
        int          n;
        int          lat;
        int          wren;
        int          nbytes;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [31:0] wd;
        logic [31:0] wa;

        exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'b00);
        nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;

        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", 32'(bus.req_ready), 32'd1);

        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = {8'h00, addr};
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        last_accept = cyc;
        if (!hold) bus.req_valid = 1'b0;

        exp_rd = 32'h0;
        exp_wd = 32'h0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (we) begin
            for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            exp_wd  = ref_word(int'(addr));
            exp_lat = (size == 2'd2) ? 2 : 4;
        end else begin
            exp_lat = 3;
            for (int i = 0; i < nbytes; i++) exp_rd[8*i +: 8] = ref_mem[int'(addr) + i];
            if (!uns) begin
                for (int i = nbytes * 8; i < 32; i++) exp_rd[i] = exp_rd[nbytes*8-1];
            end
        end

        lat  = 1;
        wren = 0;
        wd   = 32'h0;
        wa   = 32'h0;
        while (bus.resp_valid !== 1'b1 && lat < 12) begin
            check_eq("busy_ready", 32'(bus.req_ready), 32'd0);
            if (bus.ram_wren) begin
                wren++;
                wd = bus.ram_write_data;
                wa = 32'(bus.ram_address);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        last_resp  = cyc;
        last_lat   = lat;
        last_rdata = bus.resp_rdata;
        last_wd    = wd;

        check_eq("resp_valid",  32'(bus.resp_valid), 32'd1);
        check_eq("latency",     lat, exp_lat);
        check_eq("resp_err",    32'(bus.resp_err), 32'(exp_err));
        check_eq("resp_rdata",  bus.resp_rdata, exp_rd);
        check_eq("resp_ready",  32'(bus.req_ready), 32'd0);
        check_eq("wren_cycles", wren, (we && !exp_err) ? 1 : 0);
        if (we && !exp_err) begin
            check_eq("wr_data", wd, exp_wd);
            check_eq("wr_addr", wa, {24'h0, addr & 8'hFC});
        end

        if (!hold) begin
            @(posedge clk);
            #1;
            check_eq("resp_pulse",  32'(bus.resp_valid), 32'd0);
            check_eq("rdata_hold",  bus.resp_rdata, exp_rd);
            check_eq("err_hold",    32'(bus.resp_err), 32'(exp_err));
        end
    endtask

    initial begin
        logic [31:0] old_w;
        logic [31:0] new_w;
        int          r1;
        int          n;

        for (int i = 0; i < 64; i++) begin
            tb_ram[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = tb_ram[i][8*b +: 8];
        end
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;

        // reset values
        #12;
        check_eq("rst_ready",   32'(bus.req_ready), 32'd1);
        check_eq("rst_valid",   32'(bus.resp_valid), 32'd0);
        check_eq("rst_err",     32'(bus.resp_err), 32'd0);
        check_eq("rst_rdata",   bus.resp_rdata, 32'h0);
        check_eq("rst_wren",    32'(bus.ram_wren), 32'd0);
        check_eq("rst_addr",    32'(bus.ram_address), 32'd0);
        check_eq("rst_wdata",   bus.ram_write_data, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // word store then word load
        do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b0);
        check_eq("ld_word_val", last_rdata, 32'hDEADBEEF);
        check_eq("ld_word_lat", last_lat, 3);

        // byte loads around a stored word
        do_req(1'b1, 2'd2, 1'b0, 8'h20, 32'h11223344, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 8'h23, 32'h0, 1'b0);
        check_eq("ld_b23_s", last_rdata, 32'h00000011);
        do_req(1'b1, 2'd0, 1'b0, 8'h21, 32'h000000FF, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 8'h21, 32'h0, 1'b0);
        check_eq("ld_b21_s", last_rdata, 32'hFFFFFFFF);
        do_req(1'b0, 2'd0, 1'b1, 8'h21, 32'h0, 1'b0);
        check_eq("ld_b21_u", last_rdata, 32'h000000FF);

        // halfword read-modify-write
        do_req(1'b1, 2'd2, 1'b0, 8'h20, 32'h11223344, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 8'h22, 32'h0000ABCD, 1'b0);
        check_eq("hw_st_wd",  last_wd, 32'hABCD3344);
        check_eq("hw_st_lat", last_lat, 4);

        // errors
        do_req(1'b0, 2'd1, 1'b0, 8'h05, 32'h0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 8'h06, 32'h12345678, 1'b0);
        do_req(1'b0, 2'd3, 1'b1, 8'h08, 32'h0, 1'b0);

        // randomized mix
        for (int k = 0; k < 150; k++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   $urandom, 1'b0);
        end

        // back-to-back with req_valid held high
        do_req(1'b1, 2'd2, 1'b0, 8'h80, $urandom, 1'b1);
        r1 = last_resp;
        do_req(1'b0, 2'd2, 1'b0, 8'h80, 32'h0, 1'b1);
        check_eq("b2b_gap", last_accept - r1, 2);
        bus.req_valid = 1'b0;

        // reset while in WR
        old_w = ref_word(8'h40);
        new_w = ~old_w;
        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 16'h0040;
        bus.req_wdata = new_w;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_eq("rst_in_wr", 32'(bus.ram_wren), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("rst_wren_drop",  32'(bus.ram_wren), 32'd0);
        check_eq("rst_addr_clr",   32'(bus.ram_address), 32'd0);
        check_eq("rst_wd_clr",     bus.ram_write_data, 32'h0);
        check_eq("rst_no_resp",    32'(bus.resp_valid), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_resp", 32'(bus.resp_valid), 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_eq("post_rst_resp",  32'(bus.resp_valid), 32'd0);
            check_eq("post_rst_wren",  32'(bus.ram_wren), 32'd0);
            check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);
        end
        check_eq("rst_mem_atomic",
                 32'((tb_ram[16] == old_w) || (tb_ram[16] == new_w)), 32'd1);
        for (int b = 0; b < 4; b++) ref_mem[64 + b] = tb_ram[16][8*b +: 8];

        // a normal operation after reset
        do_req(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, 1'b0);

        // final memory image
        for (int i = 0; i < 64; i++) check_eq("mem_word", tb_ram[i], ref_word(4*i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default `RAM_ADDRESS_BITWIDTH, byte-address width on both sides.
REQ-002 SHALL have ports, in order:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend sub-word loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data.
- resp_err  out  1  misaligned or illegal request; qualified by resp_valid.
- ram_wren  out  1  word-RAM write enable.
- ram_address  out  ADDR_W  word-RAM byte address.
- ram_write_data  out  32  word-RAM write data.
- ram_data  in  32  word-RAM read data; valid the cycle after the address was sampled.

Function
REQ-003 SHALL accept a request on a rising edge where req_valid && req_ready; it SHALL latch all req_* fields at that edge.
REQ-004 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR, RESP; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-005 SHALL transition from IDLE on acceptance:
- error → RESP.
- word store → WR.
- load or sub-word store → RD_ADDR.
REQ-006 SHALL transition RD_ADDR → RD_DATA unconditionally.
REQ-007 SHALL transition from RD_DATA:
- load → RESP.
- sub-word store → WR.
REQ-008 SHALL transition WR → RESP, and RESP → IDLE, unconditionally.
REQ-009 SHALL drive ram_address = {latched addr[ADDR_W-1:2], 2'b00} in RD_ADDR, RD_DATA and WR, and 0 otherwise.
REQ-010 SHALL assert ram_wren only in WR, for exactly one cycle per store.
REQ-011 SHALL sample ram_data only on the RD_DATA→next edge.
REQ-012 SHALL use little-endian lanes:
- byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
- halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
REQ-013 SHALL extract the addressed lane for a load, sign-extend to 32 bits when req_unsigned = 0, zero-extend when 1, and register the result into resp_rdata.
REQ-014 SHALL build a sub-word store by read-modify-write: replace only the addressed lane of the captured ram_data with the low 8/16 bits of req_wdata, hold the result in ram_write_data during WR, and preserve the other bytes unchanged.
REQ-015 SHALL drive ram_write_data = latched req_wdata during WR for a word store.
REQ-016 SHALL flag an error for:
- halfword with addr[0] = 1;
- word with addr[1:0] != 0;
- req_size = 3.
On error: no RAM access, resp_err = 1, resp_rdata = 0.
REQ-017 SHALL give resp_rdata = 0 and resp_err = 0 for every successful store.
REQ-018 SHALL meet these latencies, as edges from acceptance to the cycle with resp_valid = 1:
- error 1, word store 2, load 3, sub-word store 4.
REQ-019 SHALL ignore req_valid outside IDLE; the next request MAY be accepted in the cycle after RESP.
REQ-020 SHALL hold resp_rdata and resp_err stable from RESP until the next completion.

Reset
REQ-021 SHALL, on rstn low and asynchronously, force:
- state IDLE, ram_wren 0, resp_valid 0, resp_err 0;
- resp_rdata 0, ram_address 0, ram_write_data 0.
req_ready SHALL be 1 after reset.
REQ-022 SHALL abort an in-flight operation when reset is asserted during it, including in WR: no further ram_wren and no resp_valid for the aborted request.

Verification
REQ-023 SHALL have a bench covering at least these scenarios:
- Word store 0xDEADBEEF at 0x10, then word load 0x10 → one ram_wren cycle; load resp_valid 3 edges after acceptance; resp_rdata 0xDEADBEEF.
- Memory word 0x11223344 at 0x20; byte load 0x23, signed → 0x00000011. Byte load 0x21, signed, after storing 0xFF there → 0xFFFFFFFF; same load unsigned → 0x000000FF.
- Memory word 0x11223344 at 0x20; halfword store 0xABCD at 0x22 → ram_write_data 0xABCD3344 in WR; resp_valid 4 edges after acceptance.
- Halfword load at 0x05, and word store at 0x06 → resp_valid 1 edge after acceptance, resp_err 1, ram_wren never 1.
- rstn pulsed low while in WR → ram_wren drops immediately; no resp_valid; req_ready 1 after release; memory word either old or fully new.
- Back-to-back requests with req_valid held high → second acceptance only in the cycle after RESP; req_ready low throughout each operation.
